// File: rtl/smart_mac_row_ctrl_pkg.sv
// Shared definitions for the smart_mac row sequencer and its cells:
// FSM state encodings and control-line polarities.
package smart_mac_row_ctrl_pkg;

    typedef enum logic [2:0] {
        SMC_IDLE,
        SMC_CLEAR,
        SMC_COMPUTE,
        SMC_DRAIN,
        SMC_FIN
    } smc_state_e;

    localparam logic OP2_CLEAR = 1'b1;
    localparam logic OP2_ACCUM = 1'b0;
    localparam logic OUT_ACC   = 1'b1;
    localparam logic OUT_PASS  = 1'b0;

    function automatic logic [31:0] sat_len(input logic [31:0] k, input logic [31:0] k_max);
        return (k > k_max) ? k_max : k;
    endfunction

endpackage

// File: rtl/smart_mac_phase_cnt.sv
// Loadable down-counter with zero flag, shared by the compute
// phase and the drain column sequencing.
module smart_mac_phase_cnt #(
    parameter int CNT_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic [CNT_W-1:0] count,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/smart_mac_row_ctrl.sv
// Row sequencer for NUM_COLS smart_mac cells: clear, skewed compute,
// then a valid/ready drain of one column result per beat.
module smart_mac_row_ctrl
    import smart_mac_row_ctrl_pkg::*;
#(
    parameter int NUM_COLS = 4,
    parameter int K_MAX    = 256,
    parameter int CNT_W    = $clog2(K_MAX + NUM_COLS) + 1,
    localparam int COL_W   = $clog2(NUM_COLS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CNT_W-1:0]    k_len,
    input  logic                stat_mode,
    output logic                busy,
    output logic                done,
    output logic                fsm_op2_select_out,
    output logic                fsm_out_select_out,
    output logic                stat_bit_out,
    output logic                operand_valid,
    output logic [NUM_COLS-1:0] select_right_out_smart,
    output logic                result_valid,
    output logic [COL_W-1:0]    result_col,
    input  logic                result_ready
);

    smc_state_e       state;
    logic [CNT_W-1:0] k_q;
    logic [CNT_W-1:0] k_sat;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_val;
    logic             cnt_load;
    logic             cnt_en;
    logic             cnt_zero;

    assign k_sat = (k_len > CNT_W'(K_MAX)) ? CNT_W'(K_MAX) : k_len;

    // COMPUTE runs k+NUM_COLS-1 cycles; drain counts the columns down.
    always_comb begin
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        cnt_val  = CNT_W'(NUM_COLS - 1);
        unique case (state)
            SMC_CLEAR: begin
                cnt_load = 1'b1;
                if (k_q != '0) cnt_val = k_q + CNT_W'(NUM_COLS - 2);
            end
            SMC_COMPUTE: begin
                cnt_load = cnt_zero;
                cnt_en   = !cnt_zero;
            end
            SMC_DRAIN: cnt_en = result_ready && !cnt_zero;
            default: ;
        endcase
    end

    smart_mac_phase_cnt #(
        .CNT_W(CNT_W)
    ) u_phase_cnt (
        .clk     (clk),
        .rst     (rst),
        .load    (cnt_load),
        .en      (cnt_en),
        .load_val(cnt_val),
        .count   (cnt),
        .zero    (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state                  <= SMC_IDLE;
            k_q                    <= '0;
            busy                   <= 1'b0;
            done                   <= 1'b0;
            fsm_op2_select_out     <= OP2_ACCUM;
            fsm_out_select_out     <= OUT_PASS;
            stat_bit_out           <= 1'b0;
            operand_valid          <= 1'b0;
            select_right_out_smart <= '0;
            result_valid           <= 1'b0;
            result_col             <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                SMC_IDLE: begin
                    if (start) begin
                        k_q                <= k_sat;
                        stat_bit_out       <= stat_mode;
                        busy               <= 1'b1;
                        fsm_op2_select_out <= OP2_CLEAR;
                        state              <= SMC_CLEAR;
                    end
                end
                SMC_CLEAR: begin
                    fsm_op2_select_out <= OP2_ACCUM;
                    if (k_q == '0) begin
                        fsm_out_select_out     <= OUT_ACC;
                        result_valid           <= 1'b1;
                        select_right_out_smart <= NUM_COLS'(1);
                        result_col             <= '0;
                        state                  <= SMC_DRAIN;
                    end else begin
                        operand_valid <= 1'b1;
                        state         <= SMC_COMPUTE;
                    end
                end
                SMC_COMPUTE: begin
                    // Next cycle is still in the first k_len when cnt-1 >= NUM_COLS-1.
                    operand_valid <= (cnt >= CNT_W'(NUM_COLS));
                    if (cnt_zero) begin
                        operand_valid          <= 1'b0;
                        fsm_out_select_out     <= OUT_ACC;
                        result_valid           <= 1'b1;
                        select_right_out_smart <= NUM_COLS'(1);
                        result_col             <= '0;
                        state                  <= SMC_DRAIN;
                    end
                end
                SMC_DRAIN: begin
                    if (result_ready) begin
                        if (cnt_zero) begin
                            fsm_out_select_out     <= OUT_PASS;
                            result_valid           <= 1'b0;
                            select_right_out_smart <= '0;
                            result_col             <= '0;
                            done                   <= 1'b1;
                            state                  <= SMC_FIN;
                        end else begin
                            select_right_out_smart <= select_right_out_smart << 1;
                            result_col             <= result_col + COL_W'(1);
                        end
                    end
                end
                SMC_FIN: begin
                    busy         <= 1'b0;
                    stat_bit_out <= 1'b0;
                    state        <= SMC_IDLE;
                end
                default: state <= SMC_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_smart_mac_row_ctrl.sv
// Directed bench for smart_mac_row_ctrl: a per-tile expected trace is
// built from the phase rules and compared every cycle.
module tb_smart_mac_row_ctrl;

    localparam int N     = 4;
    localparam int KM    = 256;
    localparam int CNT_W = $clog2(KM + N) + 1;
    localparam int COL_W = $clog2(N);
    localparam int VW    = 7 + N + COL_W;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] k_len;
    logic             stat_mode;
    logic             busy;
    logic             done;
    logic             op2_sel;
    logic             out_sel;
    logic             stat_bit;
    logic             operand_valid;
    logic [N-1:0]     sel;
    logic             result_valid;
    logic [COL_W-1:0] result_col;
    logic             result_ready;

    int    checks = 0;
    int    errors = 0;
    string tag = "none";
    logic [VW-1:0] exp_q[$];

    always #5 clk = ~clk;

    smart_mac_row_ctrl #(
        .NUM_COLS(N),
        .K_MAX   (KM)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .start                 (start),
        .k_len                 (k_len),
        .stat_mode             (stat_mode),
        .busy                  (busy),
        .done                  (done),
        .fsm_op2_select_out    (op2_sel),
        .fsm_out_select_out    (out_sel),
        .stat_bit_out          (stat_bit),
        .operand_valid         (operand_valid),
        .select_right_out_smart(sel),
        .result_valid          (result_valid),
        .result_col            (result_col),
        .result_ready          (result_ready)
    );

    function automatic logic [VW-1:0] pack(
        input bit b, input bit d, input bit o2, input bit os,
        input bit st, input bit ov, input logic [N-1:0] s,
        input bit rv, input int col
    );
        return {b, d, o2, os, st, ov, rv, s, COL_W'(col)};
    endfunction

    function automatic logic [N-1:0] onehot(input int col);
        logic [N-1:0] v;
        v = '0;
        v[col] = 1'b1;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Compare process: one expected vector per cycle while a trace is queued.
    initial begin
        logic [VW-1:0] e;
        logic [VW-1:0] a;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {busy, done, op2_sel, out_sel, stat_bit, operand_valid,
                     result_valid, sel, result_col};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL %s trace t=%0t: got %b expected %b", tag, $time, a, e);
                end
            end
        end
    end

    task automatic run_tile(
        input string nm, input int k, input bit s,
        input int st_at, input int st_len,
        input int xs0, input int xs1,
        input int rst_at, input int lit_done
    );
        int kk, d0, col, c, fin, done_at, done_seen;
        bit rdy[0:699];
        logic [VW-1:0] tr[$];
        logic [VW-1:0] z;
        z  = '0;
        kk = (k > KM) ? KM : k;
        d0 = 2 + ((kk > 0) ? kk + N - 1 : 0);
        for (int j = 0; j < 700; j++)
            rdy[j] = !(st_len > 0 && j >= st_at && j < st_at + st_len);
        tr.push_back(z);
        tr.push_back(pack(1, 0, 1, 0, s, 0, '0, 0, 0));
        for (int j = 2; j < d0; j++)
            tr.push_back(pack(1, 0, 0, 0, s, (j - 2) < kk, '0, 0, 0));
        col = 0;
        c   = d0;
        while (col < N) begin
            tr.push_back(pack(1, 0, 0, 1, s, 0, onehot(col), 1, col));
            if (rdy[c]) col++;
            c++;
        end
        fin = c;
        tr.push_back(pack(1, 1, 0, 0, s, 0, '0, 0, 0));
        tr.push_back(z);
        if (rst_at >= 0) begin
            while (tr.size() > rst_at + 1) void'(tr.pop_back());
            tr.push_back(z);
        end
        chk({nm, " model_done"}, fin, lit_done);
        tag = nm;
        foreach (tr[i]) exp_q.push_back(tr[i]);
        done_seen = 0;
        done_at   = -1;
        for (int j = 0; j < tr.size(); j++) begin
            start        = (j == 0) || (j == xs0) || (j == xs1);
            k_len        = CNT_W'(k);
            stat_mode    = s;
            result_ready = rdy[j];
            rst          = (j == rst_at);
            if (done) begin
                done_seen++;
                done_at = j;
            end
            @(posedge clk);
            #1;
        end
        start        = 1'b0;
        rst          = 1'b0;
        result_ready = 1'b1;
        if (rst_at < 0) begin
            chk({nm, " done_count"}, done_seen, 1);
            chk({nm, " done_cycle"}, done_at, lit_done);
        end else begin
            chk({nm, " done_count"}, done_seen, 0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        k_len        = '0;
        stat_mode    = 1'b0;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        tag = "reset";
        repeat (3) exp_q.push_back('0);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(posedge clk);
        #1;

        run_tile("basic_k4",   4,   0, -1, 0, -1, -1, -1, 13);
        run_tile("k0",         0,   0, -1, 0, -1, -1, -1, 6);
        run_tile("stall_col2", 4,   0, 11, 3, -1, -1, -1, 16);
        run_tile("start_ign",  4,   1, -1, 0, 4,  13, -1, 13);
        run_tile("rst_drain",  2,   0, -1, 0, -1, -1, 8,  11);
        run_tile("after_rst",  3,   0, -1, 0, -1, -1, -1, 12);
        run_tile("kmax_stat",  KM,  1, -1, 0, -1, -1, -1, 265);
        run_tile("k_sat",      300, 1, -1, 0, -1, -1, -1, 265);
        run_tile("k1",         1,   0, -1, 0, -1, -1, -1, 10);

        chk("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
